// File: rtl/dmem_map_pkg.sv
// Memory map shared by the data-memory responder and the processor-side bench.
package dmem_map_pkg;

  localparam logic [31:0] MMIO_CYCLE_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_LED_ADDR     = 32'hFFFF_0001;
  localparam logic [31:0] MMIO_ERRSTAT_ADDR = 32'hFFFF_0002;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE,
    REG_LED,
    REG_ERRSTAT,
    REG_UNMAPPED
  } region_e;

  // Full 32-bit decode: RAM only when every bit above the word index is zero.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned addr_width);
    region_e region;
    if ((addr >> addr_width) == 32'd0) begin
      region = REG_RAM;
    end else if (addr == MMIO_CYCLE_ADDR) begin
      region = REG_CYCLE;
    end else if (addr == MMIO_LED_ADDR) begin
      region = REG_LED;
    end else if (addr == MMIO_ERRSTAT_ADDR) begin
      region = REG_ERRSTAT;
    end else begin
      region = REG_UNMAPPED;
    end
    return region;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped registers: free-running cycle counter, LED register and bus-error state.
module mmio_regs
  import dmem_map_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LED_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  region_e               i_region,
  input  logic                  i_wren,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [LED_WIDTH-1:0]  o_led,
  output logic                  o_bus_error,
  output logic [7:0]            o_err_count
);

  logic [DATA_WIDTH-1:0] r_cycle;
  logic [LED_WIDTH-1:0]  r_led;
  logic                  r_bus_error;
  logic [7:0]            r_err_count;

  logic w_wr_cycle;
  logic w_wr_led;
  logic w_wr_errstat;
  logic w_unmapped;

  assign w_wr_cycle   = i_wren && (i_region == REG_CYCLE);
  assign w_wr_led     = i_wren && (i_region == REG_LED);
  assign w_wr_errstat = i_wren && (i_region == REG_ERRSTAT);
  // Every cycle is a read, so an unmapped address counts once per cycle, write or not.
  assign w_unmapped   = (i_region == REG_UNMAPPED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle     <= '0;
      r_led       <= '0;
      r_bus_error <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_cycle <= w_wr_cycle ? i_wdata : r_cycle + DATA_WIDTH'(1);
      if (w_wr_led) begin
        r_led <= i_wdata[LED_WIDTH-1:0];
      end
      if (w_wr_errstat) begin
        r_bus_error <= 1'b0;
        r_err_count <= 8'd0;
      end else if (w_unmapped) begin
        r_bus_error <= 1'b1;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_region)
      REG_CYCLE:   o_rdata = r_cycle;
      REG_LED:     o_rdata = DATA_WIDTH'(r_led);
      REG_ERRSTAT: o_rdata = DATA_WIDTH'({r_bus_error, r_err_count});
      default:     o_rdata = '0;
    endcase
  end

  assign o_led       = r_led;
  assign o_bus_error = r_bus_error;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory port responder: word RAM plus MMIO, writes on rising edge, reads on falling edge.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LED_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_dmem,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q_dmem,
  output logic [LED_WIDTH-1:0]  led,
  output logic                  bus_error,
  output logic [7:0]            err_count
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  region_e               w_region;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic [DATA_WIDTH-1:0] w_mmio_rdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_mem [Depth];

  assign w_region  = decode_region(address_dmem, ADDR_WIDTH);
  assign w_ram_idx = address_dmem[ADDR_WIDTH-1:0];

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (wren && (w_region == REG_RAM)) begin
      r_mem[w_ram_idx] <= data;
    end
  end

  mmio_regs #(
    .DATA_WIDTH(DATA_WIDTH),
    .LED_WIDTH (LED_WIDTH)
  ) u_mmio_regs (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_region   (w_region),
    .i_wren     (wren),
    .i_wdata    (data),
    .o_rdata    (w_mmio_rdata),
    .o_led      (led),
    .o_bus_error(bus_error),
    .o_err_count(err_count)
  );

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_RAM:      w_rdata = r_mem[w_ram_idx];
      REG_UNMAPPED: w_rdata = '0;
      default:      w_rdata = w_mmio_rdata;
    endcase
  end

  // Falling-edge load gives the processor a result before its next rising edge.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_rdata;
    end
  end

  assign q_dmem = r_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [15:0] led;
  logic        bus_error;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clock = ~clock;

  dmem_responder #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .LED_WIDTH (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .led         (led),
    .bus_error   (bus_error),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every pending expectation against the value loaded at the last falling edge.
  task automatic drain();
    string       t;
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, q_dmem, e);
    end
  endtask

  // Drive one processor cycle after the rising edge; the read result is checked after the
  // falling edge of the same cycle.
  task automatic do_cycle(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                          input logic chk, input logic [31:0] exp, input string tag);
    @(posedge clock);
    #1;
    address_dmem = addr;
    data         = wdata;
    wren         = wen;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clock);
    #1;
    drain();
  endtask

  initial begin
    reset        = 1'b1;
    address_dmem = 32'd0;
    data         = 32'd0;
    wren         = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("rst_q", q_dmem, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);
    check("rst_ecnt", 32'(err_count), 32'd0);
    @(negedge clock);
    #1;
    reset = 1'b1;

    // RAM write, read-after-write, same-cycle old data
    do_cycle(32'd6, 32'd0, 1'b1, 1'b0, 32'd0, "");
    do_cycle(32'd7, 32'd11, 1'b1, 1'b0, 32'd0, "");
    do_cycle(32'd0, 32'h0BAD_F00D, 1'b1, 1'b0, 32'd0, "");
    do_cycle(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, "");
    do_cycle(32'd5, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, "raw_5");
    do_cycle(32'd6, 32'd0, 1'b0, 1'b1, 32'd0, "ram_6");
    do_cycle(32'd7, 32'd22, 1'b1, 1'b1, 32'd11, "wr_old_7");
    do_cycle(32'd7, 32'd0, 1'b0, 1'b1, 32'd22, "wr_new_7");

    // LED register
    do_cycle(MMIO_LED_ADDR, 32'h0001_2345, 1'b1, 1'b0, 32'd0, "");
    do_cycle(MMIO_LED_ADDR, 32'd0, 1'b0, 1'b1, 32'h0000_2345, "led_read");
    check("led_out", 32'(led), 32'h0000_2345);

    // CYCLE load and wrap
    do_cycle(MMIO_CYCLE_ADDR, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, "");
    do_cycle(MMIO_CYCLE_ADDR, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, "cyc_load");
    do_cycle(MMIO_CYCLE_ADDR, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, "cyc_max");
    do_cycle(MMIO_CYCLE_ADDR, 32'd0, 1'b0, 1'b1, 32'd0, "cyc_wrap");

    // Unmapped writes saturate the error count and leave RAM alone
    for (int i = 0; i < 300; i++) begin
      do_cycle(32'h0000_4000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, "");
    end
    do_cycle(MMIO_ERRSTAT_ADDR, 32'd0, 1'b0, 1'b1, 32'h0000_01FF, "errstat_sat");
    check("berr_set", 32'(bus_error), 32'd1);
    check("ecnt_sat", 32'(err_count), 32'h0000_00FF);
    do_cycle(32'd0, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D, "ram_0_kept");
    do_cycle(MMIO_ERRSTAT_ADDR, 32'h1234_5678, 1'b1, 1'b0, 32'd0, "");
    do_cycle(MMIO_ERRSTAT_ADDR, 32'd0, 1'b0, 1'b1, 32'd0, "errstat_clr");
    check("berr_clr", 32'(bus_error), 32'd0);
    check("ecnt_clr", 32'(err_count), 32'd0);

    // Unmapped reads: upper address bits and the hole just past ERRSTAT
    do_cycle(32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'd0, "unmap_hi");
    do_cycle(32'hFFFF_0003, 32'd0, 1'b0, 1'b1, 32'd0, "unmap_hole");
    do_cycle(MMIO_ERRSTAT_ADDR, 32'd0, 1'b0, 1'b1, 32'h0000_0102, "errstat_rd");

    // Mid-run reset with CYCLE = 37 and led = 00A5
    do_cycle(MMIO_LED_ADDR, 32'h0000_00A5, 1'b1, 1'b0, 32'd0, "");
    do_cycle(MMIO_CYCLE_ADDR, 32'd37, 1'b1, 1'b0, 32'd0, "");
    do_cycle(MMIO_CYCLE_ADDR, 32'd0, 1'b0, 1'b1, 32'd37, "cyc_37");
    check("led_a5", 32'(led), 32'h0000_00A5);
    reset = 1'b0;
    #1;
    check("mid_rst_q", q_dmem, 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_berr", 32'(bus_error), 32'd0);
    check("mid_rst_ecnt", 32'(err_count), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    exp_q.push_back(32'd3);
    tag_q.push_back("cyc_after_rst");
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory port. It serves the address_dmem / data / wren / q_dmem interface from an internal word-addressed RAM plus a small memory-mapped I/O region.
- Sits in the top-level wrapper between the pipelined processor and board I/O, and replaces the plain dmem instance.
- Provides sw write commit, lw read return in time for the processor's M/W register, a free-running cycle counter, an LED register and bus-error tracking.

Parameters:
- ADDR_WIDTH, 12: RAM word-address bits; RAM depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; must equal the processor data width.
- LED_WIDTH, 16: width of the LED register.

Ports:
- clock  input  1: master clock.
- reset  input  1: asynchronous, active-low reset; asserted when 0.
- address_dmem  input  32: word address from the processor's X/M output register.
- data  input  DATA_WIDTH: store data from the processor.
- wren  input  1: store enable; high for sw in M stage.
- q_dmem  output  DATA_WIDTH: load data, sampled by the processor at the next rising edge.
- led  output  LED_WIDTH: LED register contents.
- bus_error  output  1: sticky flag, set by any unmapped access.
- err_count  output  8: saturating count of unmapped accesses.

Behaviour:
Address decode, one word per address:
- RAM: address_dmem[31:ADDR_WIDTH] == 0.
- CYCLE: 32'hFFFF_0000; read/write.
- LED: 32'hFFFF_0001; read/write; reads are zero-extended.
- ERRSTAT: 32'hFFFF_0002; read returns {23'b0, bus_error, err_count}; any write clears both.
- Anything else is unmapped: reads return 0, writes are dropped, and the access is counted as an error.

Writes:
- Commit on the rising edge while wren = 1.
- RAM writes store data at address_dmem[ADDR_WIDTH-1:0].

Reads:
- q_dmem is a register loaded on the falling edge from the current address_dmem.
- Result: data is valid half a cycle after the address and before the processor's next rising edge, so the effective latency is zero pipeline cycles.
- Read-after-write: a falling-edge read sees any write committed at the preceding rising edge. A lw immediately following a sw to the same address returns the new value.
- While wren = 1, q_dmem still loads the pre-write contents of the addressed location.

CYCLE counter:
- Increments by 1 on every rising edge and wraps from 32'hFFFF_FFFF to 0.
- A write on the same edge loads the data value instead of incrementing.

Error accounting:
- An unmapped access is any edge where the address is unmapped and either wren = 1 or the access is a read.
- Reads are only counted when an enable is present, so qualify them by treating every cycle as a read. Counting happens only when wren = 1, or on the falling-edge read, once per cycle.
- On an unmapped access: set bus_error, and increment err_count, saturating at 8'hFF.
- A write to ERRSTAT on the same edge as an error-qualifying event: the clear wins.

Reset:
- Asynchronous on the falling edge of reset, effective immediately, including mid-cycle or between the write and read edges.
- Values while reset = 0: q_dmem = 0, CYCLE = 0, led = 0, bus_error = 0, err_count = 0.
- RAM contents are not cleared (don't-care after power-up, preserved across reset).
- On release, CYCLE reads 1 after the first rising edge.

Width rules:
- The full 32-bit address is always decoded; upper bits are never ignored.
- LED writes take data[LED_WIDTH-1:0].

Decomposition:
- Shared package dmem_map_pkg:
  - Constants for MMIO_CYCLE_ADDR, MMIO_LED_ADDR and MMIO_ERRSTAT_ADDR.
  - A region-select enum {REG_RAM, REG_CYCLE, REG_LED, REG_ERRSTAT, REG_UNMAPPED}.
  - A combinational decode function (address → region) shared with the processor-side bench.
- One natural sub-module, mmio_regs: holds the CYCLE counter, LED register and error state, and returns its read mux output. The RAM array and q_dmem register stay in the top.

Test Plan:
- Reset low mid-run with CYCLE = 37, led = 16'h00A5 → all outputs read 0 immediately. After release and 3 rising edges, a lw at 32'hFFFF_0000 returns 3 ± the 1-cycle read offset; the bench checks an exact 3 after reset deassertion aligned to a falling edge.
- sw 32'hDEADBEEF to 5, then lw 5 the next cycle → q_dmem = 32'hDEADBEEF at the processor sample edge. lw 6 (never written after a known write of 0) → 0.
- Same cycle, wren = 1 at address 7 (old value 11, data 22) → q_dmem = 11 that cycle and 22 on the following cycle's read.
- sw 32'h0001_2345 to LED → led = 16'h2345. A read of the LED address returns 32'h0000_2345.
- CYCLE write of 32'hFFFF_FFFE → reads 32'hFFFF_FFFF then 0 on successive cycles (wrap).
- 300 writes to 32'h0000_4000 (unmapped with ADDR_WIDTH = 12) → bus_error = 1, err_count = 8'hFF, RAM unchanged. A write to ERRSTAT → both return to 0 on the next edge.
